// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction-fetch stage feeding the decoder.
// Keeps the fetch PC, issues one word request at a time to a
// variable-latency instruction memory, and presents each returned
// instruction with its PC in an output register under valid/ready.
// A redirect retargets the fetch PC; a response that was already in
// flight when the redirect arrived is discarded rather than presented.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4
);

  // IDLE: no request outstanding; WAIT: request outstanding, response wanted;
  // DROP: request outstanding but a redirect made its response stale.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] redirect_tgt;
  logic        load_resp;
  logic        consume;

  // Redirect targets are always word aligned; the low two bits are dropped.
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // A response is presented only when it answers a live request and no
  // redirect arrives in the same cycle (redirect wins).
  assign load_resp = (state == S_WAIT) && !redirect_valid && imem_valid;
  assign consume   = out_valid && out_ready;

  // Request only when nothing is outstanding and the output register will
  // have room by the time the response lands (empty or being consumed now).
  assign imem_req  = rst && (state == S_IDLE) && !redirect_valid &&
                     (!out_valid || out_ready);
  assign imem_addr = fetch_pc;
  assign out_pc4   = out_pc + 32'd4;

  // Fetch control: state transitions and fetch PC updates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          // Stray responses in IDLE (e.g. left over from before a reset) are ignored.
          if (redirect_valid) begin
            fetch_pc <= redirect_tgt;
          end else if (imem_req) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_tgt;
            state    <= imem_valid ? S_IDLE : S_DROP;
          end else if (imem_valid) begin
            fetch_pc <= fetch_pc + 32'd4;
            state    <= S_IDLE;
          end
        end
        S_DROP: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_tgt;
          end
          if (imem_valid) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output register: redirect flushes, a live response loads, a handshake drains.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_inst  <= NOP_INST;
      out_pc    <= 32'd0;
    end else begin
      if (redirect_valid) begin
        out_valid <= 1'b0;
      end else if (load_resp) begin
        out_valid <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
      if (load_resp) begin
        out_inst <= imem_rdata;
        out_pc   <= fetch_pc;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction model.
module tb_inst_fetch_unit;

  localparam logic [31:0] A   = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;

  int checks   = 0;
  int failures = 0;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pc4        (out_pc4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        iv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        chk_reg;
  } vec_t;

  vec_t vecs [21];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic iv,
                              input logic [31:0] rd, input logic e_req,
                              input logic [31:0] e_addr, input logic e_ov,
                              input logic [31:0] e_pc, input logic [31:0] e_inst,
                              input logic chk_reg);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.iv = iv; v.rdata = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc;
    v.e_inst = e_inst; v.chk_reg = chk_reg;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic rdy, input logic rv,
                     input logic [31:0] rpc, input logic iv, input logic [31:0] rd);
    rst = r; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    imem_valid = iv; imem_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs compared 1 time unit after drive, well clear of the clock edges.
  task automatic expect_io(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_ov, input logic [31:0] e_pc,
                           input logic [31:0] e_inst, input logic chk_reg);
    #1;
    chk({tag, ".req"},  {31'd0, imem_req},  {31'd0, e_req});
    chk({tag, ".addr"}, imem_addr, e_addr);
    chk({tag, ".ov"},   {31'd0, out_valid}, {31'd0, e_ov});
    if (e_ov || chk_reg) begin
      chk({tag, ".pc"},   out_pc, e_pc);
      chk({tag, ".inst"}, out_inst, e_inst);
    end
    if (e_ov) chk({tag, ".pc4"}, out_pc4, e_pc + 32'd4);
  endtask

  task automatic do_reset();
    drv(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (3) step();
  endtask

  // Transaction-level reference model state
  bit          m_inflight, m_stale, m_valid;
  logic [31:0] m_pc, m_opc, m_oinst;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic        r_rst, r_rdy, r_rv, r_iv, e_req, deliver;
  logic [31:0] r_rpc, r_rd;

  initial begin
    // ---------------- table-driven: reset, streaming, backpressure, redirects
    vecs[0]  = mk(0,1,0,0,0,0,                    0,A,        0,0,NOP,1);
    vecs[1]  = mk(1,1,0,0,0,0,                    1,A,        0,0,0,0);
    vecs[2]  = mk(1,1,0,0,1,memf(A),              0,A,        0,0,0,0);
    vecs[3]  = mk(1,1,0,0,0,0,                    1,A+4,      1,A,memf(A),0);
    vecs[4]  = mk(1,1,0,0,1,memf(A+4),            0,A+4,      0,0,0,0);
    vecs[5]  = mk(1,1,0,0,0,0,                    1,A+8,      1,A+4,memf(A+4),0);
    vecs[6]  = mk(1,0,0,0,1,memf(A+8),            0,A+8,      0,0,0,0);
    for (int i = 7; i <= 11; i++)
      vecs[i] = mk(1,0,0,0,0,0,                   0,A+12,     1,A+8,memf(A+8),0);
    vecs[12] = mk(1,1,0,0,0,0,                    1,A+12,     1,A+8,memf(A+8),0);
    vecs[13] = mk(1,1,0,0,1,memf(A+12),           0,A+12,     0,0,0,0);
    vecs[14] = mk(1,0,1,32'h0040_0103,0,0,        0,A+16,     1,A+12,memf(A+12),0);
    vecs[15] = mk(1,1,0,0,0,0,                    1,32'h0040_0100,0,0,0,0);
    vecs[16] = mk(1,1,1,32'h0050_0008,1,32'hDEAD_BEEF,0,32'h0040_0100,0,0,0,0);
    vecs[17] = mk(1,1,0,0,0,0,                    1,32'h0050_0008,0,0,0,0);
    vecs[18] = mk(1,1,0,0,1,32'h1111_1111,        0,32'h0050_0008,0,0,0,0);
    vecs[19] = mk(1,1,0,0,0,0,                    1,32'h0050_000C,1,32'h0050_0008,32'h1111_1111,0);
    vecs[20] = mk(1,1,0,0,0,0,                    0,32'h0050_000C,0,0,0,0);

    do_reset();
    for (int i = 0; i < 21; i++) begin
      drv(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rpc, vecs[i].iv, vecs[i].rdata);
      expect_io($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_ov,
                vecs[i].e_pc, vecs[i].e_inst, vecs[i].chk_reg);
      step();
    end

    // ---------------- redirect while a 3-cycle fetch is in flight
    do_reset();
    drv(1,1,0,0,0,0);                        expect_io("rif0", 1, A, 0, 0, 0, 0); step();
    drv(1,1,1,32'h0040_0103,0,0);            expect_io("rif1", 0, A, 0, 0, 0, 0); step();
    drv(1,1,0,0,0,0);                        expect_io("rif2", 0, 32'h0040_0100, 0, 0, 0, 0); step();
    drv(1,1,0,0,1,32'hBAD0_BAD0);            expect_io("rif3", 0, 32'h0040_0100, 0, 0, 0, 0); step();
    drv(1,1,0,0,0,0);                        expect_io("rif4", 1, 32'h0040_0100, 0, 0, 0, 0); step();
    drv(1,1,0,0,1,32'hCAFE_0001);            expect_io("rif5", 0, 32'h0040_0100, 0, 0, 0, 0); step();
    drv(1,1,0,0,0,0);                        expect_io("rif6", 1, 32'h0040_0104, 1, 32'h0040_0100, 32'hCAFE_0001, 0); step();

    // ---------------- reset while waiting; late response must be ignored
    do_reset();
    drv(1,1,0,0,0,0);                        expect_io("mrs0", 1, A, 0, 0, 0, 0); step();
    drv(0,1,0,0,0,0);                        expect_io("mrs1", 0, A, 0, 0, 0, 0); step();
    drv(0,1,0,0,0,0);                        expect_io("mrs2", 0, A, 0, 0, NOP, 1); step();
    drv(1,1,0,0,1,32'h0BAD_F00D);            expect_io("mrs3", 1, A, 0, 0, NOP, 1); step();
    drv(1,1,0,0,0,0);                        expect_io("mrs4", 0, A, 0, 0, NOP, 1); step();
    drv(1,1,0,0,1,32'h1234_5678);            expect_io("mrs5", 0, A, 0, 0, 0, 0); step();
    drv(1,0,0,0,0,0);                        expect_io("mrs6", 0, A+4, 1, A, 32'h1234_5678, 0); step();

    // ---------------- PC wrap at the top of the address space
    do_reset();
    drv(1,1,1,32'hFFFF_FFFF,0,0);            expect_io("wrp0", 0, A, 0, 0, 0, 0); step();
    drv(1,1,0,0,0,0);                        expect_io("wrp1", 1, 32'hFFFF_FFFC, 0, 0, 0, 0); step();
    drv(1,1,0,0,1,32'h0000_0073);            expect_io("wrp2", 0, 32'hFFFF_FFFC, 0, 0, 0, 0); step();
    drv(1,1,0,0,0,0);                        expect_io("wrp3", 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h0000_0073, 0); step();

    // ---------------- randomized traffic against the transaction model
    do_reset();
    m_inflight = 0; m_stale = 0; m_valid = 0; m_pc = A; m_opc = 0; m_oinst = NOP;
    mem_cnt = 0; mem_addr = 0;
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 99) != 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rv  = ($urandom_range(0, 9) == 0);
      r_rpc = $urandom;
      if ($urandom_range(0, 7) == 0) r_rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      r_iv = 1'b0;
      r_rd = $urandom;
      if (mem_cnt == 1) begin
        r_iv = 1'b1;
        r_rd = memf(mem_addr);
      end else if (mem_cnt == 0 && !m_inflight && $urandom_range(0, 7) == 0) begin
        r_iv = 1'b1;
      end
      drv(r_rst, r_rdy, r_rv, r_rpc, r_iv, r_rd);
      e_req = r_rst && !m_inflight && !r_rv && (!m_valid || r_rdy);
      expect_io($sformatf("rnd%0d", c), e_req, m_pc, m_valid, m_opc, m_oinst, 0);
      step();
      if (mem_cnt > 0) mem_cnt--;
      if (e_req) begin
        mem_cnt  = $urandom_range(1, 4);
        mem_addr = m_pc;
      end
      if (!r_rst) begin
        m_inflight = 0; m_stale = 0; m_valid = 0; m_pc = A; m_opc = 0; m_oinst = NOP;
      end else begin
        deliver = 1'b0;
        if (m_inflight && r_iv) begin
          m_inflight = 0;
          deliver = !m_stale && !r_rv;
          m_stale = 0;
        end else if (m_inflight && r_rv) begin
          m_stale = 1;
        end
        if (r_rv) m_valid = 0;
        else if (deliver) begin
          m_valid = 1; m_oinst = r_rd; m_opc = m_pc;
        end else if (m_valid && r_rdy) m_valid = 0;
        if (r_rv) m_pc = r_rpc & 32'hFFFF_FFFC;
        else if (deliver) m_pc = m_pc + 32'd4;
        if (e_req) begin
          m_inflight = 1; m_stale = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
